regfile_panel_ctrl: RTL

//  Front-panel controller sitting directly upstream/downstream of the 32x32 register file.

---
 rtl/regfile_panel_ctrl_pkg.sv | 28 ++
 rtl/regfile_panel_ctrl_if.sv | 32 +++
 rtl/regfile_panel_ctrl_step.sv | 42 ++++
 rtl/regfile_panel_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/regfile_panel_ctrl_pkg.sv
// Shared types and constants for the front-panel register-file controller.
// Holds the FSM encoding, byte-lane indices, default widths and the debug view.
package regfile_panel_ctrl_pkg;

    localparam int SIZE_DEF     = 5;
    localparam int WIDTH_DEF    = 32;
    localparam int LEDSIZE_DEF  = 8;
    localparam int DEBOUNCE_DEF = 16;
    localparam int LANES        = 4;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        READ   = 2'd2
    } state_t;

    typedef struct packed {
        state_t             state;
        logic [LANES-1:0]   lane_valid;
        logic               step_p;
    } dbg_t;

endpackage

// File: rtl/regfile_panel_ctrl_if.sv
// Board-side and register-file-side signals of the panel controller.
// Step is a raw button level (no ready); Write_Reg is a one-cycle write strobe; R_Data_* are combinational reads of R_Addr_*.
interface regfile_panel_ctrl_if #(
    parameter int SIZE    = 5,
    parameter int WIDTH   = 32,
    parameter int LEDSIZE = 8
);
    logic [SIZE-1:0]    Address;
    logic               RW;
    logic               AB;
    logic [1:0]         CS;
    logic [LEDSIZE-1:0] Data_In;
    logic               Step;
    logic [SIZE-1:0]    R_Addr_A;
    logic [SIZE-1:0]    R_Addr_B;
    logic [SIZE-1:0]    W_Addr;
    logic [WIDTH-1:0]   W_Data;
    logic               Write_Reg;
    logic [WIDTH-1:0]   R_Data_A;
    logic [WIDTH-1:0]   R_Data_B;
    logic [LEDSIZE-1:0] LED;

    modport slave (
        input  Address, RW, AB, CS, Data_In, Step, R_Data_A, R_Data_B,
        output R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, LED
    );

    modport master (
        output Address, RW, AB, CS, Data_In, Step, R_Data_A, R_Data_B,
        input  R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, LED
    );
endinterface

// File: rtl/regfile_panel_ctrl_step.sv
// Push-button conditioner: 2-flop synchroniser, saturating stable-high counter,
// and a rising-edge detector producing one pulse per debounced press.
module step_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] SAT  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          level, level_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            if (!sync2) begin
                cnt   <= '0;
                level <= 1'b0;
            end else begin
                // Counter parks at SAT so a held button never re-arms the edge.
                if (cnt != SAT) cnt <= cnt + 1'b1;
                if (cnt == LAST) level <= 1'b1;
            end
        end
    end

    assign pulse = level & ~level_d;
endmodule

// File: rtl/regfile_panel_ctrl.sv
// Front-panel controller: assembles a register-file write word byte by byte
// from switches, drives both read ports, and shows one read byte on the LEDs.
module regfile_panel_ctrl
    import regfile_panel_ctrl_pkg::*;
#(
    parameter int SIZE            = SIZE_DEF,
    parameter int WIDTH           = WIDTH_DEF,
    parameter int LEDSIZE         = LEDSIZE_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    regfile_panel_ctrl_if.slave  bus,
    output dbg_t                 dbg
);
    state_t             state, state_n;
    logic               step_p;
    logic               write_reg;
    logic [LANES-1:0]   lane_valid;
    logic [LANES-1:0]   lane_after;
    logic [SIZE-1:0]    r_addr_a, r_addr_b, w_addr;
    logic [WIDTH-1:0]   w_data, display;
    logic [LEDSIZE-1:0] led;
    logic               ab_q;

    step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .Clk   (Clk),
        .Reset (Reset),
        .raw   (bus.Step),
        .pulse (step_p)
    );

    // Lane set as it will be once the current byte lands; decides the commit.
    assign lane_after = lane_valid | (LANES'(1) << bus.CS);

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        write_reg = 1'b0;
        case (state)
            IDLE: begin
                if (step_p) begin
                    if (!bus.RW)        state_n = READ;
                    else if (&lane_after) state_n = COMMIT;
                end
            end
            COMMIT: begin
                write_reg = 1'b1;
                state_n   = IDLE;
            end
            READ:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lane_valid <= '0;
            w_data     <= '0;
            w_addr     <= '0;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            ab_q       <= 1'b0;
            display    <= '0;
            led        <= '0;
        end else begin
            if (state == IDLE && step_p) begin
                if (bus.RW) begin
                    w_data[bus.CS*LEDSIZE +: LEDSIZE] <= bus.Data_In;
                    lane_valid[bus.CS]                <= 1'b1;
                    if (&lane_after) w_addr <= bus.Address;
                end else begin
                    if (bus.AB) r_addr_b <= bus.Address;
                    else        r_addr_a <= bus.Address;
                    ab_q <= bus.AB;
                end
            end
            if (state == COMMIT) lane_valid <= '0;
            if (state == READ)   display    <= ab_q ? bus.R_Data_B : bus.R_Data_A;
            led <= display[bus.CS*LEDSIZE +: LEDSIZE];
        end
    end

    assign bus.R_Addr_A  = r_addr_a;
    assign bus.R_Addr_B  = r_addr_b;
    assign bus.W_Addr    = w_addr;
    assign bus.W_Data    = w_data;
    assign bus.Write_Reg = write_reg;
    assign bus.LED       = led;

    assign dbg.state      = state;
    assign dbg.lane_valid = lane_valid;
    assign dbg.step_p     = step_p;
endmodule
